// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial sum deserializer.
// Optional build macro: SERIAL_DESER_MSB_FIRST_EN selects an MSB-first stream.
package serial_deser_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } deser_state_e;

  // Word position for the k-th accepted bit of a word.
  function automatic int unsigned bit_pos(input int unsigned k, input int unsigned width);
`ifdef SERIAL_DESER_MSB_FIRST_EN
    return width - 1 - k;
`else
    // k is always below width in use; the guard keeps both arguments meaningful.
    return (k < width) ? k : 0;
`endif
  endfunction

endpackage

// File: rtl/serial_sum_deserializer_if.sv
// Serial input stream, parallel output word and error signals of the deserializer.
// master: the environment side (serial source plus word consumer); slave: the deserializer.
interface serial_sum_deserializer_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ERR_CNT_W = 8
);

  logic                 in_bit;
  logic                 in_valid;
  logic                 in_first;
  logic                 in_carry;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_word;
  logic                 out_carry;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_frame;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_bit, in_valid, in_first, in_carry, out_ready,
    input  in_ready, out_word, out_carry, out_valid, err_frame, err_cnt
  );

  modport slave (
    input  in_bit, in_valid, in_first, in_carry, out_ready,
    output in_ready, out_word, out_carry, out_valid, err_frame, err_cnt
  );

endinterface

// File: rtl/serial_deser_out_reg.sv
// Single-entry output holding register with valid/ready.
// A load in the same cycle as a consume replaces the word without a bubble; the caller
// only loads when the slot is empty or being consumed.
module serial_deser_out_reg #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] word_i,
  input  logic             carry_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] word_o,
  output logic             carry_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] word_q, word_d;
  logic             carry_q, carry_d;

  // Next-state: load wins, otherwise a consume empties the slot, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    carry_d = carry_q;
    if (load_i) begin
      valid_d = 1'b1;
      word_d  = word_i;
      carry_d = carry_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      carry_q <= carry_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/serial_sum_deserializer.sv
// Collects a bit-serial sum stream plus the adder's final carry into parallel words.
// Framing errors (stray bits in idle, restart mid-word) pulse err_frame and bump a
// saturating counter. Build macro SERIAL_DESER_MSB_FIRST_EN makes the stream MSB-first.
module serial_sum_deserializer
  import serial_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  serial_sum_deserializer_if.slave deser_io
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  deser_state_e         state_q, state_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic                 err_frame_q, err_frame_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_ready;
  logic             accept;
  logic             last_bit;
  logic [IdxW-1:0]  pos_cur;
  logic [IdxW-1:0]  pos_zero;
  logic [WIDTH-1:0] merged;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic             out_valid;

  assign last_bit = (bit_idx_q == IdxW'(WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only accepted bits move the FSM.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        StIdle:    if (deser_io.in_first) state_d = StCollect;
        StCollect: if (!deser_io.in_first && last_bit) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Handshake, bit placement, word completion and framing-error detection.
  always_comb begin
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    err_frame_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    load        = 1'b0;
    pos_cur     = IdxW'(bit_pos(32'(bit_idx_q), WIDTH));
    pos_zero    = IdxW'(bit_pos(32'd0, WIDTH));
    merged      = shift_q;
    merged[pos_cur] = deser_io.in_bit;
    load_word   = merged;

    // Stall only the final bit, and only while a previous word is still unconsumed.
    in_ready = !((state_q == StCollect) && last_bit && out_valid && !deser_io.out_ready);
    accept   = deser_io.in_valid && in_ready;

    if (accept) begin
      if (deser_io.in_first) begin
        // New word start; any partial word is dropped.
        err_frame_d       = (state_q == StCollect);
        shift_d           = '0;
        shift_d[pos_zero] = deser_io.in_bit;
        bit_idx_d         = IdxW'(1);
      end else if (state_q == StIdle) begin
        err_frame_d = 1'b1;
      end else if (last_bit) begin
        load      = 1'b1;
        shift_d   = '0;
        bit_idx_d = '0;
      end else begin
        shift_d   = merged;
        bit_idx_d = bit_idx_q + IdxW'(1);
      end
    end

    if (err_frame_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Collection and error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_q   <= '0;
      shift_q     <= '0;
      err_frame_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      err_frame_q <= err_frame_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  serial_deser_out_reg #(
    .Width (WIDTH)
  ) u_out_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .word_i  (load_word),
    .carry_i (deser_io.in_carry),
    .ready_i (deser_io.out_ready),
    .valid_o (out_valid),
    .word_o  (deser_io.out_word),
    .carry_o (deser_io.out_carry)
  );

  assign deser_io.in_ready  = in_ready;
  assign deser_io.out_valid = out_valid;
  assign deser_io.err_frame = err_frame_q;
  assign deser_io.err_cnt   = err_cnt_q;

endmodule
